// File: rtl/keypad_pkg.sv
// Shared types and scan-code constants for the keypad numeric-entry controller.
package keypad_pkg;

  typedef enum logic [2:0] {DIG, DOT, CLEAR, BKSP, ENTER, BAD} action_t;
  typedef enum logic [1:0] {IDLE, INT, FRAC, DONE} state_t;

  typedef struct packed {
    action_t    act;
    logic [3:0] dig;
  } key_act_t;

  // Raw 4x4 matrix scan codes; only keypad_decode interprets these.
  localparam logic [3:0] SC_0     = 4'b0000;
  localparam logic [3:0] SC_1     = 4'b1100;
  localparam logic [3:0] SC_2     = 4'b1101;
  localparam logic [3:0] SC_3     = 4'b1110;
  localparam logic [3:0] SC_4     = 4'b1000;
  localparam logic [3:0] SC_5     = 4'b1001;
  localparam logic [3:0] SC_6     = 4'b1010;
  localparam logic [3:0] SC_7     = 4'b0100;
  localparam logic [3:0] SC_8     = 4'b0101;
  localparam logic [3:0] SC_9     = 4'b0110;
  localparam logic [3:0] SC_DOT   = 4'b0001;
  localparam logic [3:0] SC_CLEAR = 4'b0010;
  localparam logic [3:0] SC_BKSP  = 4'b0011;
  localparam logic [3:0] SC_ENTER = 4'b1111;

endpackage

// File: rtl/keypad_entry_if.sv
// Key-strobe input and committed-value outputs of the keypad entry controller.
interface keypad_entry_if #(
    parameter int DIGITS = 4
);
    localparam int CW = $clog2(DIGITS + 1);

    logic                  key_valid;
    logic [3:0]            key;
    logic [4*DIGITS-1:0]   digits;
    logic [CW-1:0]         ndigits;
    logic [CW-1:0]         nfrac;
    logic                  dot_en;
    logic                  entry_done;
    logic                  commit;
    logic                  key_err;

    modport master (
        output key_valid, key,
        input  digits, ndigits, nfrac, dot_en, entry_done, commit, key_err
    );

    modport slave (
        input  key_valid, key,
        output digits, ndigits, nfrac, dot_en, entry_done, commit, key_err
    );

endinterface

// File: rtl/keypad_decode.sv
// Combinational scan code to {action, digit} decoder.
module keypad_decode
    import keypad_pkg::*;
(
    input  logic [3:0] key,
    output key_act_t   act
);

    always_comb begin
        // NOTE: default first so every path assigns act; no latch is inferred.
        act.act = BAD;
        act.dig = 4'd0;
        unique case (key)
            SC_0:     begin act.act = DIG; act.dig = 4'd0; end
            SC_1:     begin act.act = DIG; act.dig = 4'd1; end
            SC_2:     begin act.act = DIG; act.dig = 4'd2; end
            SC_3:     begin act.act = DIG; act.dig = 4'd3; end
            SC_4:     begin act.act = DIG; act.dig = 4'd4; end
            SC_5:     begin act.act = DIG; act.dig = 4'd5; end
            SC_6:     begin act.act = DIG; act.dig = 4'd6; end
            SC_7:     begin act.act = DIG; act.dig = 4'd7; end
            SC_8:     begin act.act = DIG; act.dig = 4'd8; end
            SC_9:     begin act.act = DIG; act.dig = 4'd9; end
            SC_DOT:   act.act = DOT;
            SC_CLEAR: act.act = CLEAR;
            SC_BKSP:  act.act = BKSP;
            SC_ENTER: act.act = ENTER;
            default:  act.act = BAD;
        endcase
    end

endmodule

// File: rtl/keypad_entry.sv
// Fixed-point BCD number entry FSM: shifts digits in/out, tracks counts, pulses commit/key_err.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int FRAC_MAX = 2
) (
    input  logic           clk,
    input  logic           rst,
    keypad_entry_if.slave  bus
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [CW-1:0] MAX_ND = CW'(DIGITS);
    localparam logic [CW-1:0] MAX_NF = CW'(FRAC_MAX);
    localparam logic [CW-1:0] ONE    = CW'(1);

    key_act_t        dec;
    state_t          state_q, state_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [CW-1:0]   nd_q, nd_d;
    logic [CW-1:0]   nf_q, nf_d;
    logic            dot_q, dot_d;
    logic            done_q, done_d;
    logic            commit_q, commit_d;
    logic            err_q, err_d;

    keypad_decode u_decode (
        .key (bus.key),
        .act (dec)
    );

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        nd_d     = nd_q;
        nf_d     = nf_q;
        dot_d    = dot_q;
        commit_d = 1'b0;
        err_d    = 1'b0;

        if (bus.key_valid) begin
            unique case (dec.act)
                CLEAR: begin
                    state_d = IDLE;
                    buf_d   = '0;
                    nd_d    = '0;
                    nf_d    = '0;
                    dot_d   = 1'b0;
                end
                DIG: begin
                    unique case (state_q)
                        IDLE, DONE: begin
                            state_d = INT;
                            buf_d   = {{(BW-4){1'b0}}, dec.dig};
                            nd_d    = ONE;
                            nf_d    = '0;
                            dot_d   = 1'b0;
                        end
                        INT: begin
                            if (nd_q < MAX_ND) begin
                                buf_d = {buf_q[BW-5:0], dec.dig};
                                nd_d  = nd_q + ONE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        FRAC: begin
                            if (nd_q < MAX_ND && nf_q < MAX_NF) begin
                                buf_d = {buf_q[BW-5:0], dec.dig};
                                nd_d  = nd_q + ONE;
                                nf_d  = nf_q + ONE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                DOT: begin
                    unique case (state_q)
                        IDLE, DONE: begin
                            // A leading dot stands for "0." so the zero counts as a digit.
                            state_d = FRAC;
                            buf_d   = '0;
                            nd_d    = ONE;
                            nf_d    = '0;
                            dot_d   = 1'b1;
                        end
                        INT: begin
                            if (FRAC_MAX == 0 || nd_q == MAX_ND) begin
                                err_d = 1'b1;
                            end else begin
                                state_d = FRAC;
                                dot_d   = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
                BKSP: begin
                    unique case (state_q)
                        INT: begin
                            if (nd_q > ONE) begin
                                buf_d = {4'd0, buf_q[BW-1:4]};
                                nd_d  = nd_q - ONE;
                            end else begin
                                state_d = IDLE;
                                buf_d   = '0;
                                nd_d    = '0;
                                nf_d    = '0;
                                dot_d   = 1'b0;
                            end
                        end
                        FRAC: begin
                            if (nf_q != '0) begin
                                buf_d = {4'd0, buf_q[BW-1:4]};
                                nd_d  = nd_q - ONE;
                                nf_d  = nf_q - ONE;
                            end else begin
                                state_d = INT;
                                dot_d   = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
                ENTER: begin
                    if (state_q == INT || state_q == FRAC) begin
                        state_d  = DONE;
                        commit_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            nd_q     <= '0;
            nf_q     <= '0;
            dot_q    <= 1'b0;
            done_q   <= 1'b0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            buf_q    <= buf_d;
            nd_q     <= nd_d;
            nf_q     <= nf_d;
            dot_q    <= dot_d;
            done_q   <= done_d;
            commit_q <= commit_d;
            err_q    <= err_d;
        end
    end

    assign bus.digits     = buf_q;
    assign bus.ndigits    = nd_q;
    assign bus.nfrac      = nf_q;
    assign bus.dot_en     = dot_q;
    assign bus.entry_done = done_q;
    assign bus.commit     = commit_q;
    assign bus.key_err    = err_q;

endmodule
